// File: rtl/jt12_pkg.sv
// Shared constants and types for the JT12 frequency sequencer.
// Address map, operator slot order and ch3 special-op mapping.
package jt12_pkg;

  localparam int SLOTS = 24;

  localparam logic [7:0] A_CH3M = 8'h27;
  localparam logic [5:0] A_FLO  = 6'b101000;
  localparam logic [5:0] A_FHI  = 6'b101001;
  localparam logic [5:0] A_SLO  = 6'b101010;
  localparam logic [5:0] A_SHI  = 6'b101011;
  localparam logic [3:0] A_DTM  = 4'h3;

  typedef enum logic [1:0] {
    OP_S1, OP_S2, OP_S3, OP_S4
  } op_e;

  // slot order within a sample: S1,S3,S2,S4
  localparam logic [7:0] OP_ORDER =
    {OP_S4, OP_S2, OP_S3, OP_S1};

  typedef struct packed {
    logic [2:0]  blk;
    logic [10:0] fnum;
  } freq_t;

  // special array index for an op position (A8:S3, A9:S1, AA:S2); 3 = none
  function automatic logic [1:0] sp_idx(
    input logic [1:0] opidx
  );
    op_e op;
    op = op_e'(OP_ORDER[{opidx, 1'b0} +: 2]);
    case (op)
      OP_S1:   return 2'd1;
      OP_S2:   return 2'd2;
      OP_S3:   return 2'd0;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/jt12_freq_dly.sv
// Clock-enabled shift register used to align per-slot fields
// to later phase generator stages.
module jt12_freq_dly #(
  parameter int W = 3,
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cen,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] sr_q [N];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) sr_q[i] <= '0;
    end else if (cen) begin
      sr_q[0] <= d_i;
      for (int i = 1; i < N; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign q_o = sr_q[N-1];

endmodule

// File: rtl/jt12_freq_seq.sv
// Frequency / detune / multiplier register store replayed as
// a 24-slot stream aligned to phase generator stages I, II and V.
module jt12_freq_seq
  import jt12_pkg::*;
#(
  parameter int DT1_DLY = 1,
  parameter int MUL_DLY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        wr,
  input  logic        part,
  input  logic [7:0]  addr,
  input  logic [7:0]  din,
  output logic [10:0] fnum_I,
  output logic [2:0]  block_I,
  output logic [2:0]  dt1_II,
  output logic [3:0]  mul_V,
  output logic        zero
);

  freq_t      chf_q [6];
  freq_t      spf_q [3];
  logic [6:0] dtm_q [SLOTS];
  logic [5:0] lat_q;
  logic [5:0] slat_q;
  logic       ch3m_q;

  logic [2:0] sch_q;
  logic [1:0] sop_q;
  freq_t      frq_q;
  logic       zero_q;

  logic       wok;
  logic [2:0] wch;
  logic [4:0] wslot;
  logic [4:0] rslot;
  logic [1:0] sp;
  freq_t      rd_d;

  assign wok = addr[1:0] != 2'd3;
  assign wch = part ? {1'b0, addr[1:0]} + 3'd3
                    : {1'b0, addr[1:0]};
  assign wslot = {1'b0, addr[3:2], 2'b00}
               + {2'b00, addr[3:2], 1'b0}
               + {2'b00, wch};
  assign rslot = {1'b0, sop_q, 2'b00}
               + {2'b00, sop_q, 1'b0}
               + {2'b00, sch_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_q  <= '0;
      slat_q <= '0;
      ch3m_q <= 1'b0;
      for (int i = 0; i < 6; i++) chf_q[i] <= '0;
      for (int i = 0; i < 3; i++) spf_q[i] <= '0;
      for (int i = 0; i < SLOTS; i++) dtm_q[i] <= '0;
    end else if (wr) begin
      unique case (1'b1)
        addr[7:2] == A_FHI && wok:
          lat_q <= din[5:0];
        addr[7:2] == A_FLO && wok:
          chf_q[wch] <= {lat_q, din};
        addr[7:2] == A_SHI && wok && !part:
          slat_q <= din[5:0];
        addr[7:2] == A_SLO && wok && !part:
          spf_q[addr[1:0]] <= {slat_q, din};
        addr == A_CH3M && !part:
          ch3m_q <= din[6];
        addr[7:4] == A_DTM && wok:
          dtm_q[wslot] <= din[6:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_d = chf_q[sch_q];
    sp   = sp_idx(sop_q);
    if (ch3m_q && sch_q == 3'd2 && sp != 2'd3)
      rd_d = spf_q[sp];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sch_q  <= '0;
      sop_q  <= '0;
      frq_q  <= '0;
      zero_q <= 1'b0;
    end else if (cen) begin
      frq_q  <= rd_d;
      zero_q <= sch_q == 3'd0 && sop_q == 2'd0;
      if (sch_q == 3'd5) begin
        sch_q <= '0;
        sop_q <= sop_q + 2'd1;
      end else begin
        sch_q <= sch_q + 3'd1;
      end
    end
  end

  jt12_freq_dly #(.W(3), .N(DT1_DLY + 1)) u_dt1 (
    .clk (clk),
    .rst (rst),
    .cen (cen),
    .d_i (dtm_q[rslot][6:4]),
    .q_o (dt1_II)
  );

  jt12_freq_dly #(.W(4), .N(MUL_DLY + 1)) u_mul (
    .clk (clk),
    .rst (rst),
    .cen (cen),
    .d_i (dtm_q[rslot][3:0]),
    .q_o (mul_V)
  );

  assign fnum_I  = frq_q.fnum;
  assign block_I = frq_q.blk;
  assign zero    = zero_q;

endmodule

// File: tb/tb_jt12_freq_seq.sv
// Directed bench for jt12_freq_seq: latch/commit, ch3 special,
// dt1/mul alignment, cen gating, wrap, invalid writes, collision.
module tb_jt12_freq_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic        wr;
  logic        part;
  logic [7:0]  addr;
  logic [7:0]  din;
  logic [10:0] fnum_I;
  logic [2:0]  block_I;
  logic [2:0]  dt1_II;
  logic [3:0]  mul_V;
  logic        zero;

  int checks = 0;
  int errors = 0;
  int slot   = 0;
  int n;

  jt12_freq_seq dut (
    .clk     (clk),
    .rst     (rst),
    .cen     (cen),
    .wr      (wr),
    .part    (part),
    .addr    (addr),
    .din     (din),
    .fnum_I  (fnum_I),
    .block_I (block_I),
    .dt1_II  (dt1_II),
    .mul_V   (mul_V),
    .zero    (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic p,
                        input logic [7:0] a,
                        input logic [7:0] d);
    part = p;
    addr = a;
    din  = d;
    wr   = 1'b1;
    step();
    wr   = 1'b0;
  endtask

  // leaves the outputs presenting slot s, counter at s+1
  task automatic run_to(input int s);
    cen = 1'b1;
    for (int i = 0; i < 24 && slot != s; i++) begin
      step();
      slot = (slot + 1) % 24;
    end
    step();
    slot = (slot + 1) % 24;
    cen = 1'b0;
  endtask

  task automatic adv(input int k);
    cen = 1'b1;
    for (int i = 0; i < k; i++) begin
      step();
      slot = (slot + 1) % 24;
    end
    cen = 1'b0;
  endtask

  task automatic chk_f(input string tag,
                       input logic [10:0] f,
                       input logic [2:0] b);
    chk({tag, "_fnum"}, 16'(fnum_I), 16'(f));
    chk({tag, "_blk"}, 16'(block_I), 16'(b));
  endtask

  initial begin
    rst = 1'b0; cen = 1'b0; wr = 1'b0;
    part = 1'b0; addr = 8'h00; din = 8'h00;
    #12;
    chk_f("rst", 11'h0, 3'd0);
    chk("rst_dt1", 16'(dt1_II), 16'h0);
    chk("rst_mul", 16'(mul_V), 16'h0);
    chk("rst_zero", 16'(zero), 16'h0);
    rst = 1'b1;
    step();
    step();
    chk("zero_nocen", 16'(zero), 16'h0);
    adv(1);
    chk("zero_first", 16'(zero), 16'h1);

    // latch / commit
    wr_reg(1'b0, 8'hA5, 8'h22);
    wr_reg(1'b0, 8'hA1, 8'h69);
    run_to(1);
    chk_f("ch1_s1", 11'h269, 3'd4);
    run_to(2);
    chk_f("ch2_empty", 11'h0, 3'd0);
    wr_reg(1'b0, 8'hA1, 8'h10);
    run_to(7);
    chk_f("ch1_s3_reuse", 11'h210, 3'd4);

    // ch3 special mode
    wr_reg(1'b0, 8'hA2, 8'h33);
    wr_reg(1'b0, 8'h27, 8'h40);
    wr_reg(1'b0, 8'hAD, 8'h1A);
    wr_reg(1'b0, 8'hA9, 8'h55);
    run_to(8);
    chk_f("sp_s3", 11'h0, 3'd0);
    run_to(20);
    chk_f("sp_s4_chan", 11'h233, 3'd4);
    run_to(2);
    chk_f("sp_s1", 11'h255, 3'd3);
    wr_reg(1'b0, 8'h27, 8'h00);
    run_to(2);
    chk_f("sp_off", 11'h233, 3'd4);

    // dt1 / mul alignment on slot 9 (S3, ch3)
    wr_reg(1'b1, 8'h34, 8'h5A);
    run_to(9);
    chk_f("s9", 11'h0, 3'd0);
    chk("dt1_pre", 16'(dt1_II), 16'h0);
    adv(1);
    chk("dt1_at1", 16'(dt1_II), 16'h5);
    chk("mul_at1", 16'(mul_V), 16'h0);
    adv(1);
    chk("dt1_at2", 16'(dt1_II), 16'h0);
    adv(1);
    chk("mul_at3", 16'(mul_V), 16'h0);
    adv(1);
    chk("mul_at4", 16'(mul_V), 16'hA);

    // cen low holds everything (outputs at slot 13)
    step(); step(); step();
    chk_f("hold", 11'h210, 3'd4);
    chk("hold_mul", 16'(mul_V), 16'hA);
    chk("hold_dt1", 16'(dt1_II), 16'h0);
    adv(1);
    chk_f("after_hold_s14", 11'h233, 3'd4);
    chk("mul_at5", 16'(mul_V), 16'h0);
    for (int i = 0; i < 8; i++) begin
      cen = (i % 2 == 0);
      step();
      if (i % 2 == 0) slot = (slot + 1) % 24;
    end
    cen = 1'b0;
    run_to(19);
    chk_f("toggle_s19", 11'h210, 3'd4);

    // wrap
    run_to(23);
    chk_f("s23", 11'h0, 3'd0);
    chk("s23_zero", 16'(zero), 16'h0);
    adv(1);
    chk("wrap_zero", 16'(zero), 16'h1);
    cen = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!zero && n < 60);
    cen = 1'b0;
    slot = (slot + n) % 24;
    chk("zero_period", 16'(n), 16'd24);

    // invalid writes
    wr_reg(1'b0, 8'hA7, 8'h3F);
    wr_reg(1'b0, 8'hA3, 8'hFF);
    wr_reg(1'b0, 8'hA0, 8'h01);
    run_to(0);
    chk_f("a7_ign", 11'h201, 3'd4);
    run_to(3);
    chk_f("a3_ign", 11'h0, 3'd0);
    wr_reg(1'b0, 8'h27, 8'h40);
    wr_reg(1'b0, 8'hAF, 8'h3F);
    wr_reg(1'b0, 8'hAA, 8'h00);
    wr_reg(1'b1, 8'hA8, 8'h77);
    run_to(8);
    chk_f("p1_a8_ign", 11'h0, 3'd0);
    run_to(14);
    chk_f("af_ign", 11'h200, 3'd3);
    wr_reg(1'b0, 8'h27, 8'h00);

    // commit collides with the read of slot 0
    run_to(23);
    part = 1'b0; addr = 8'hA0; din = 8'h05;
    wr = 1'b1; cen = 1'b1;
    step();
    wr = 1'b0; cen = 1'b0;
    slot = (slot + 1) % 24;
    chk_f("coll_old", 11'h201, 3'd4);
    chk("coll_zero", 16'(zero), 16'h1);
    run_to(0);
    chk_f("coll_new", 11'h205, 3'd4);

    // asynchronous reset mid-stream, pending latch dropped
    wr_reg(1'b0, 8'hA5, 8'h3F);
    #3;
    rst = 1'b0;
    #1;
    chk_f("arst", 11'h0, 3'd0);
    chk("arst_zero", 16'(zero), 16'h0);
    chk("arst_dt1", 16'(dt1_II), 16'h0);
    chk("arst_mul", 16'(mul_V), 16'h0);
    step();
    rst = 1'b1;
    slot = 0;
    wr_reg(1'b0, 8'hA0, 8'h11);
    run_to(0);
    chk_f("post_rst", 11'h011, 3'd0);
    chk("post_rst_zero", 16'(zero), 16'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
